// File: rtl/car_odometer_if.sv
// Dashboard odometer bus: car mode, wheel movement and trip clear in; BCD mileage and status out.
interface car_odometer_if;
  logic [1:0]  mode;
  logic        move_in;
  logic        clear;
  logic [15:0] mile;
  logic        unit_pulse;
  logic        overflow;

  modport master (output mode, move_in, clear, input mile, unit_pulse, overflow);
  modport slave  (input mode, move_in, clear, output mile, unit_pulse, overflow);
endinterface

// File: rtl/car_odometer.sv
// Wheel-tick odometer: prescales move_in rising edges into distance units and keeps a
// saturating 4-digit packed-BCD mileage that is cleared on trip clear or power-off.
module car_odometer #(
  parameter int TICKS_PER_UNIT = 100
) (
  input logic           clk,
  input logic           reset,
  car_odometer_if.slave bus
);

  // TICKS_PER_UNIT = 1 would give a zero-width prescaler; keep one bit that never leaves 0.
  localparam int PRE_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_UNIT - 1);

  logic [15:0]      mile_q, mile_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             overflow_q, overflow_d;
  logic             unit_pulse_q, unit_pulse_d;
  logic             move_prev_q, move_prev_d;
  logic [1:0]       mode_prev_q, mode_prev_d;

  logic tick;
  logic power_off;
  logic unit_req;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    tick      = bus.move_in & ~move_prev_q & (bus.mode != 2'b00);
    power_off = (mode_prev_q != 2'b00) && (bus.mode == 2'b00);
    unit_req  = tick && (pre_q == PRE_MAX);

    mile_d       = mile_q;
    pre_d        = pre_q;
    overflow_d   = overflow_q;
    unit_pulse_d = 1'b0;
    move_prev_d  = bus.move_in;
    mode_prev_d  = bus.mode;

    if (bus.clear || power_off) begin
      mile_d     = 16'h0000;
      pre_d      = '0;
      overflow_d = 1'b0;
    end else if (unit_req) begin
      // The prescaler wraps even when the unit is lost at 9999.
      pre_d = '0;
      if (mile_q != 16'h9999) begin
        mile_d       = bcd_inc(mile_q);
        unit_pulse_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (tick) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Stage boundary: all state and outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      mile_q       <= 16'h0000;
      pre_q        <= '0;
      overflow_q   <= 1'b0;
      unit_pulse_q <= 1'b0;
      move_prev_q  <= 1'b1;
      mode_prev_q  <= 2'b00;
    end else begin
      mile_q       <= mile_d;
      pre_q        <= pre_d;
      overflow_q   <= overflow_d;
      unit_pulse_q <= unit_pulse_d;
      move_prev_q  <= move_prev_d;
      mode_prev_q  <= mode_prev_d;
    end
  end

  assign bus.mile       = mile_q;
  assign bus.unit_pulse = unit_pulse_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_car_odometer.sv
// Bench for car_odometer: directed scenarios plus random traffic on a TICKS_PER_UNIT=4
// and a TICKS_PER_UNIT=1 instance, both checked against an integer mileage model.
module tb_car_odometer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  car_odometer_if if4 ();
  car_odometer_if if1 ();

  car_odometer #(.TICKS_PER_UNIT(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
  car_odometer #(.TICKS_PER_UNIT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 tracks the /4 instance, index 1 the /1 instance.
  int m_tpu[2] = '{4, 1};
  int m_miles[2];
  int m_pend[2];
  bit m_ovf[2];
  bit m_pulse[2];
  bit m_pmove[2];
  bit [1:0] m_pmode[2];

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic bit nibbles_ok(input logic [15:0] v);
    bit ok = 1'b1;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic step(input logic r, input logic [1:0] m, input logic mv, input logic clr);
    bit rise;
    @(negedge clk);
    reset = r;
    if4.mode = m; if4.move_in = mv; if4.clear = clr;
    if1.mode = m; if1.move_in = mv; if1.clear = clr;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_miles[k] = 0; m_pend[k] = 0; m_ovf[k] = 0; m_pulse[k] = 0;
        m_pmove[k] = 1; m_pmode[k] = 2'b00;
      end else begin
        rise = mv && !m_pmove[k] && (m != 2'b00);
        m_pulse[k] = 0;
        if (clr || (m_pmode[k] != 2'b00 && m == 2'b00)) begin
          m_miles[k] = 0; m_pend[k] = 0; m_ovf[k] = 0;
        end else if (rise) begin
          m_pend[k]++;
          if (m_pend[k] == m_tpu[k]) begin
            m_pend[k] = 0;
            if (m_miles[k] < 9999) begin
              m_miles[k]++;
              m_pulse[k] = 1;
            end else begin
              m_ovf[k] = 1;
            end
          end
        end
        m_pmove[k] = mv;
        m_pmode[k] = m;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    checks += 6;
    if (if4.mile !== 16'h0000) begin errors++; $display("FAIL reset_mile4 got=%h exp=0000", if4.mile); end
    if (if4.unit_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse4 got=%b exp=0", if4.unit_pulse); end
    if (if4.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf4 got=%b exp=0", if4.overflow); end
    if (if1.mile !== 16'h0000) begin errors++; $display("FAIL reset_mile1 got=%h exp=0000", if1.mile); end
    if (if1.unit_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse1 got=%b exp=0", if1.unit_pulse); end
    if (if1.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf1 got=%b exp=0", if1.overflow); end
  endtask

  task automatic test_prescale();
    int pulses = 0;
    bit bad = 0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 2'b01, 1'b1, 1'b0);
      if (if4.unit_pulse) pulses++;
      if (if4.unit_pulse !== ((k % 4) == 3)) bad = 1;
      step(1'b0, 2'b01, 1'b0, 1'b0);
      if (if4.unit_pulse !== 1'b0) bad = 1;
    end
    checks += 4;
    if (if4.mile !== 16'h0003) begin errors++; $display("FAIL prescale_mile got=%h exp=0003", if4.mile); end
    if (pulses !== 3) begin errors++; $display("FAIL prescale_pulses got=%0d exp=3", pulses); end
    if (bad !== 1'b0) begin errors++; $display("FAIL prescale_pulse_timing got=%b exp=0", bad); end
    if (if4.overflow !== 1'b0) begin errors++; $display("FAIL prescale_ovf got=%b exp=0", if4.overflow); end
  endtask

  task automatic test_bcd_ripple();
    bit bad = 0;
    do_reset();
    for (int k = 0; k < 1099; k++) begin
      step(1'b0, 2'b01, 1'b1, 1'b0);
      if (!nibbles_ok(if1.mile)) bad = 1;
      step(1'b0, 2'b01, 1'b0, 1'b0);
    end
    checks += 1;
    if (if1.mile !== 16'h1099) begin errors++; $display("FAIL ripple_preload got=%h exp=1099", if1.mile); end
    step(1'b0, 2'b01, 1'b1, 1'b0);
    if (!nibbles_ok(if1.mile)) bad = 1;
    checks += 3;
    if (if1.mile !== 16'h1100) begin errors++; $display("FAIL ripple_step got=%h exp=1100", if1.mile); end
    if (if1.unit_pulse !== 1'b1) begin errors++; $display("FAIL ripple_pulse got=%b exp=1", if1.unit_pulse); end
    if (bad !== 1'b0) begin errors++; $display("FAIL ripple_nibbles got=%b exp=0", bad); end
    step(1'b0, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    bit bad = 0;
    do_reset();
    for (int k = 0; k < 9999; k++) begin
      step(1'b0, 2'b01, 1'b1, 1'b0);
      step(1'b0, 2'b01, 1'b0, 1'b0);
    end
    checks += 2;
    if (if1.mile !== 16'h9999) begin errors++; $display("FAIL sat_reach got=%h exp=9999", if1.mile); end
    if (if1.overflow !== 1'b0) begin errors++; $display("FAIL sat_ovf_early got=%b exp=0", if1.overflow); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'b01, 1'b1, 1'b0);
      if (if1.mile !== 16'h9999 || if1.unit_pulse !== 1'b0 || if1.overflow !== 1'b1) bad = 1;
      step(1'b0, 2'b01, 1'b0, 1'b0);
      if (if1.overflow !== 1'b1) bad = 1;
    end
    checks += 1;
    if (bad !== 1'b0) begin errors++; $display("FAIL sat_hold got=%h/%b exp=9999/1", if1.mile, if1.overflow); end
    step(1'b0, 2'b01, 1'b0, 1'b1);
    checks += 2;
    if (if1.mile !== 16'h0000) begin errors++; $display("FAIL sat_clear_mile got=%h exp=0000", if1.mile); end
    if (if1.overflow !== 1'b0) begin errors++; $display("FAIL sat_clear_ovf got=%b exp=0", if1.overflow); end
    step(1'b0, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_power_off();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'b01, 1'b1, 1'b0);
      step(1'b0, 2'b01, 1'b0, 1'b0);
    end
    step(1'b0, 2'b10, 1'b0, 1'b0);
    checks += 1;
    if (if4.mile !== 16'h0001) begin errors++; $display("FAIL pwr_mode_change got=%h exp=0001", if4.mile); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'b10, 1'b1, 1'b0);
      step(1'b0, 2'b10, 1'b0, 1'b0);
    end
    step(1'b0, 2'b00, 1'b0, 1'b0);
    checks += 1;
    if (if4.mile !== 16'h0000) begin errors++; $display("FAIL pwr_off_clear got=%h exp=0000", if4.mile); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'b00, 1'b1, 1'b0);
      step(1'b0, 2'b00, 1'b0, 1'b0);
    end
    checks += 1;
    if (if4.mile !== 16'h0000) begin errors++; $display("FAIL pwr_off_ignore got=%h exp=0000", if4.mile); end
    step(1'b0, 2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'b01, 1'b1, 1'b0);
      step(1'b0, 2'b01, 1'b0, 1'b0);
    end
    checks += 2;
    if (if4.mile !== 16'h0001) begin errors++; $display("FAIL pwr_resume got=%h exp=0001", if4.mile); end
    if (if4.overflow !== 1'b0) begin errors++; $display("FAIL pwr_ovf got=%b exp=0", if4.overflow); end
  endtask

  task automatic test_held_reset();
    step(1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 2'b01, 1'b1, 1'b0);
    checks += 1;
    if (if1.mile !== 16'h0000) begin errors++; $display("FAIL held_no_count got=%h exp=0000", if1.mile); end
    step(1'b0, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0);
    checks += 1;
    if (if1.mile !== 16'h0001) begin errors++; $display("FAIL held_one_count got=%h exp=0001", if1.mile); end
  endtask

  task automatic test_clear_edge();
    do_reset();
    step(1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b1);
    checks += 2;
    if (if1.mile !== 16'h0000) begin errors++; $display("FAIL clr_edge_mile got=%h exp=0000", if1.mile); end
    if (if1.unit_pulse !== 1'b0) begin errors++; $display("FAIL clr_edge_pulse got=%b exp=0", if1.unit_pulse); end
    step(1'b0, 2'b01, 1'b0, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b0);
    checks += 2;
    if (if1.mile !== 16'h0001) begin errors++; $display("FAIL clr_next_mile got=%h exp=0001", if1.mile); end
    if (if1.unit_pulse !== 1'b1) begin errors++; $display("FAIL clr_next_pulse got=%b exp=1", if1.unit_pulse); end
    step(1'b0, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] m = 2'b01;
    logic r, mv, clr;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      r   = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 149) == 0);
      mv  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) m = 2'($urandom_range(0, 3));
      step(r, m, mv, clr);
      checks += 6;
      if (if4.mile !== to_bcd(m_miles[0])) begin errors++; $display("FAIL rnd_mile4 cyc=%0d got=%h exp=%h", k, if4.mile, to_bcd(m_miles[0])); end
      if (if4.unit_pulse !== m_pulse[0]) begin errors++; $display("FAIL rnd_pulse4 cyc=%0d got=%b exp=%b", k, if4.unit_pulse, m_pulse[0]); end
      if (if4.overflow !== m_ovf[0]) begin errors++; $display("FAIL rnd_ovf4 cyc=%0d got=%b exp=%b", k, if4.overflow, m_ovf[0]); end
      if (if1.mile !== to_bcd(m_miles[1])) begin errors++; $display("FAIL rnd_mile1 cyc=%0d got=%h exp=%h", k, if1.mile, to_bcd(m_miles[1])); end
      if (if1.unit_pulse !== m_pulse[1]) begin errors++; $display("FAIL rnd_pulse1 cyc=%0d got=%b exp=%b", k, if1.unit_pulse, m_pulse[1]); end
      if (if1.overflow !== m_ovf[1]) begin errors++; $display("FAIL rnd_ovf1 cyc=%0d got=%b exp=%b", k, if1.overflow, m_ovf[1]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    if4.mode = 2'b01; if4.move_in = 1'b0; if4.clear = 1'b0;
    if1.mode = 2'b01; if1.move_in = 1'b0; if1.clear = 1'b0;
    test_reset();
    test_prescale();
    test_bcd_ripple();
    test_saturate();
    test_power_off();
    test_held_reset();
    test_clear_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/car_odometer.md
# car_odometer

Mileage source for the car dashboard. Counts rising edges of the wheel-movement signal, divides them into distance units, and keeps a saturating 4-digit packed-BCD mileage value. That value feeds the dashboard's 16-bit BCD `mile` display input directly. Counting follows the car's power/drive mode, so mileage only accumulates while the car is on.

## Interface
- TICKS_PER_UNIT, 100: rising edges of `move_in` per one mileage unit; legal range 1..65535.
- clk  input  1  system clock, 500 Hz domain shared with the display driver.
- reset  input  1  reset, synchronous, active-high; clock clk.
- mode  input  2  car mode: 2'b00 OFF, 2'b01 manual, 2'b10 auto, 2'b11 semi-auto.
- move_in  input  1  movement level from the drive logic, already synchronous to clk; each rising edge is one tick.
- clear  input  1  synchronous trip clear, active-high, single- or multi-cycle.
- mile  output  16  packed BCD mileage, `[15:12]` thousands … `[3:0]` units; every nibble always 0..9.
- unit_pulse  output  1  high for exactly one cycle when `mile` increments.
- overflow  output  1  sticky; set when a unit is lost at 9999.

## Operation
- Edge detect: register `move_prev`. A tick is `move_in & ~move_prev` and `mode != 2'b00`. `move_prev` resets to 1, so a level held high through reset is not counted.
- Prescaler `pre`, width clog2(TICKS_PER_UNIT), range 0..TICKS_PER_UNIT-1:
  - A tick with `pre == TICKS_PER_UNIT-1` sets `pre` to 0 and raises a unit request.
  - Any other tick increments `pre`.
  - With TICKS_PER_UNIT = 1, every tick is a unit request.
- BCD increment on a unit request:
  - Units digit +1; a digit at 9 wraps to 0 and carries into the next digit; ripple is through all four digits in one cycle.
  - The request is granted only if `mile != 16'h9999`. A granted request pulses `unit_pulse`.
  - At 16'h9999 the request is dropped: `mile` holds, `overflow` sets, `unit_pulse` stays low, and `pre` still wraps to 0.
- Power-off: a transition from any non-OFF mode into 2'b00 (registered `mode_prev`) clears `mile`, `pre` and `overflow` in that cycle.
  - Mode changes among 01/10/11 do not disturb any state.
  - In OFF, ticks are ignored and `move_prev` keeps tracking `move_in`.
- Clear: `clear` high zeroes `mile`, `pre` and `overflow` every cycle it is high. It takes priority over a simultaneous unit request: that tick is discarded and `unit_pulse` stays low.
- Priority per cycle: reset > clear / power-off transition > unit increment > prescaler advance.

## Timing
- Reset values:
  - `mile` = 16'h0000, `unit_pulse` = 0, `overflow` = 0.
  - Internal: `pre` = 0, `move_prev` = 1, `mode_prev` = 2'b00.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: a rising edge of `move_in` first sampled at clock edge N is counted at edge N. If it completes a unit, the new `mile` and `unit_pulse` = 1 are visible after edge N; `unit_pulse` drops after edge N+1 unless another unit completes.
- Maximum count rate: one tick per two cycles (high then low). A `move_in` held high counts once.
- `clear` or a power-off transition at edge N: `mile` = 0 after edge N. A tick sampled at N+1 is counted normally.
- Reset asserted mid-count drops `pre` progress. Deassertion takes effect at the next edge.

## Test plan
- TICKS_PER_UNIT=4, mode=01, 12 clean pulses (1 high / 1 low): `mile` = 16'h0003, three single-cycle `unit_pulse`s, one after every 4th rising edge, `overflow` = 0.
- TICKS_PER_UNIT=1, preload via 1099 pulses, then one more pulse: `mile` steps 16'h1099 -> 16'h1100 in one cycle, with no invalid nibble at any cycle.
- TICKS_PER_UNIT=1, reach 16'h9999, then 3 pulses: `mile` stays 16'h9999, `overflow` = 1 from the first extra pulse, `unit_pulse` stays low; then `clear` -> `mile` = 0, `overflow` = 0.
- TICKS_PER_UNIT=4, mode=10, 3 pulses, then mode=00, then 4 pulses, then mode=01 and 4 pulses:
  - The 01->…->00 entry clears state.
  - Pulses in OFF are ignored.
  - Final `mile` = 16'h0001 (the pre-OFF `pre` = 3 was discarded).
- `move_in` held at 1 across reset release for 20 cycles, then low, then one pulse (TICKS_PER_UNIT=1): exactly one count, `mile` = 16'h0001.
- TICKS_PER_UNIT=1, `clear` asserted in the same cycle as a rising edge: `mile` = 0 and `unit_pulse` = 0; the next pulse gives `mile` = 16'h0001.
